// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   8N1 serial transmitter fed from the low byte of the register file (uart_reg).
//   A tx_start request captures tx_data and sends start bit, 8 data bits LSB
//   first and a stop bit on tx_serial. A one-deep holding buffer accepts one more
//   byte while a frame is in flight; it is chained onto the line with no idle gap.
//
//   Ports:
//     cpu_clk     in   single clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     tx_data     in   [7:0] byte to send, sampled only on a tx_start cycle
//     tx_start    in   send request, one request per sampled cycle
//     tx_serial   out  UART line, idles high
//     tx_busy     out  frame in flight or holding buffer occupied
//     tx_done     out  1-cycle pulse on the last cycle of each stop bit
//     tx_overrun  out  1-cycle pulse when a request is dropped (buffer full)
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | line high, waiting for tx_start
//   START | start bit (line low)
//   DATA  | data bits shift_reg[bit_idx], LSB first
//   STOP  | stop bit (line high); chains to START if a byte is pending

module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       cpu_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is armed one cycle before the stop bit ends
    localparam logic [15:0] DONE_ARM = 16'(CLKS_PER_BIT - 2);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [7:0]  hold_reg;
    logic        hold_valid;
    logic        bit_end;
    logic        stop_end;

    assign bit_end  = (baud_cnt == BIT_LAST);
    assign stop_end = (state == STOP) && bit_end;

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_overrun <= 1'b0;

            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
            end

            // Requests during a frame go to the holding buffer. The STOP
            // bit_end cycle is handled below, where the buffer drains at the
            // same time and a new byte can always be accepted.
            if (state != IDLE && tx_start && !stop_end) begin
                if (!hold_valid) begin
                    hold_reg   <= tx_data;
                    hold_valid <= 1'b1;
                end else begin
                    tx_overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    baud_cnt  <= '0;
                    if (tx_start) begin
                        shift_reg <= tx_data;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx   <= '0;
                        tx_serial <= shift_reg[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            tx_serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= shift_reg[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (baud_cnt == DONE_ARM) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (hold_valid) begin
                            // held byte goes out next; a same-cycle request refills the buffer
                            shift_reg  <= hold_reg;
                            hold_valid <= tx_start;
                            if (tx_start) begin
                                hold_reg <= tx_data;
                            end
                            tx_serial  <= 1'b0;
                            state      <= START;
                        end else if (tx_start) begin
                            // request on the final cycle chains straight on, no idle gap
                            shift_reg <= tx_data;
                            tx_serial <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//   Directed bench for uart_tx_ctrl: one instance at 4 clocks per bit and one
//   at 868 clocks per bit. Line, done, overrun and busy are logged per cycle so
//   each frame can be checked bit by bit against the expected 8N1 pattern.

module tb_uart_tx_ctrl;

    localparam int LOG_N = 16384;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data,   tx_data_b;
    logic       tx_start,  tx_start_b;
    logic       tx_serial, tx_serial_b;
    logic       tx_busy,   tx_busy_b;
    logic       tx_done,   tx_done_b;
    logic       tx_overrun, tx_overrun_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic line_log [0:LOG_N-1];
    logic done_log [0:LOG_N-1];
    logic ovr_log  [0:LOG_N-1];
    logic busy_log [0:LOG_N-1];
    logic line_b   [0:LOG_N-1];
    logic done_b   [0:LOG_N-1];
    logic busy_b   [0:LOG_N-1];

    uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut (
        .cpu_clk    (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overrun (tx_overrun)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(868)) dut_b (
        .cpu_clk    (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data_b),
        .tx_start   (tx_start_b),
        .tx_serial  (tx_serial_b),
        .tx_busy    (tx_busy_b),
        .tx_done    (tx_done_b),
        .tx_overrun (tx_overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            line_log[cyc] <= tx_serial;
            done_log[cyc] <= tx_done;
            ovr_log[cyc]  <= tx_overrun;
            busy_log[cyc] <= tx_busy;
            line_b[cyc]   <= tx_serial_b;
            done_b[cyc]   <= tx_done_b;
            busy_b[cyc]   <= tx_busy_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Number of set entries in [a, b] of the selected log.
    function automatic int cnt(input int which, input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < LOG_N) begin
                case (which)
                    0: c += int'(line_log[i]);
                    1: c += int'(done_log[i]);
                    2: c += int'(ovr_log[i]);
                    3: c += int'(busy_log[i]);
                    4: c += int'(line_b[i]);
                    5: c += int'(done_b[i]);
                    default: c += int'(busy_b[i]);
                endcase
            end
        end
        return c;
    endfunction

    // Called at a negedge; returns the cycle index of frame cycle 1.
    task automatic issue(input logic [7:0] b, output int s);
        tx_data  = b;
        tx_start = 1'b1;
        s = cyc + 1;
        tick(1);
        tx_start = 1'b0;
    endtask

    // Frame starting at cycle s, 4 clocks per bit: start, b[0..7], stop.
    task automatic check_frame(input string tag, input int s, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            logic [3:0] got;
            for (int j = 0; j < 4; j++) got[j] = line_log[s + 4*i + j];
            chk($sformatf("%s_bit%0d", tag, i), 32'(got), 32'({4{bits[i]}}));
        end
        chk({tag, "_done_at40"}, 32'(done_log[s + 39]), 32'd1);
        chk({tag, "_done_once"}, 32'(cnt(1, s, s + 39)), 32'd1);
    endtask

    initial begin
        int s, s2, k, r;
        rst_n      = 1'b1;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        tx_start_b = 1'b0;
        tx_data_b  = 8'h00;
        #3 rst_n = 1'b0;
        tick(2);
        chk("rst_serial",  32'(tx_serial),  32'd1);
        chk("rst_busy",    32'(tx_busy),    32'd0);
        chk("rst_done",    32'(tx_done),    32'd0);
        chk("rst_overrun", 32'(tx_overrun), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // single byte A5
        issue(8'hA5, s);
        tick(45);
        check_frame("a5", s, 8'hA5);
        chk("a5_busy_c1",    32'(busy_log[s]),      32'd1);
        chk("a5_busy_c40",   32'(busy_log[s + 39]), 32'd1);
        chk("a5_busy_c41",   32'(busy_log[s + 40]), 32'd0);
        chk("a5_line_idle",  32'(line_log[s + 40]), 32'd1);
        chk("a5_pre_idle",   32'(line_log[s - 1]),  32'd1);

        // back-to-back 55 then 0F, 5 cycles apart
        issue(8'h55, s);
        tick(4);
        issue(8'h0F, k);
        tick(90);
        s2 = s + 40;
        check_frame("b2b_55", s, 8'h55);
        check_frame("b2b_0f", s2, 8'h0F);
        chk("b2b_done_gap",  32'(done_log[s + 39] & done_log[s2 + 39]), 32'd1);
        chk("b2b_busy_mid",  32'(cnt(3, s, s2 + 39)), 32'd80);
        chk("b2b_overrun",   32'(cnt(2, s, s2 + 45)), 32'd0);

        // overrun: 01, 02, 03 on consecutive cycles
        tx_data  = 8'h01;
        tx_start = 1'b1;
        k = cyc;
        s = k + 1;
        tick(1);
        tx_data = 8'h02;
        tick(1);
        tx_data = 8'h03;
        tick(1);
        tx_start = 1'b0;
        tick(95);
        check_frame("ovr_01", s, 8'h01);
        check_frame("ovr_02", s + 40, 8'h02);
        chk("ovr_pulse_at",  32'(ovr_log[k + 3]), 32'd1);
        chk("ovr_pulse_one", 32'(cnt(2, k, s + 90)), 32'd1);
        chk("ovr_no_03",     32'(cnt(0, s + 80, s + 90)), 32'd11);
        chk("ovr_busy_end",  32'(busy_log[s + 80]), 32'd0);

        // data stability: C3 with tx_data scrambled during the frame
        issue(8'hC3, s);
        for (int i = 0; i < 44; i++) begin
            tx_data = 8'($urandom);
            tick(1);
        end
        check_frame("stab_c3", s, 8'hC3);

        // asynchronous reset mid-DATA with a byte pending in the holding buffer
        issue(8'h00, s);
        tick(1);
        issue(8'hAA, k);
        tick(10);
        chk("mid_pre_serial", 32'(tx_serial), 32'd0);
        chk("mid_pre_busy",   32'(tx_busy),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_serial",  32'(tx_serial),  32'd1);
        chk("mid_rst_busy",    32'(tx_busy),    32'd0);
        chk("mid_rst_done",    32'(tx_done),    32'd0);
        chk("mid_rst_overrun", 32'(tx_overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        tick(55);
        chk("mid_hold_dropped_line", 32'(cnt(0, r + 1, r + 50)), 32'd50);
        chk("mid_hold_dropped_busy", 32'(cnt(3, r + 1, r + 50)), 32'd0);

        // 868 clocks per bit, byte 00
        tx_data_b  = 8'h00;
        tx_start_b = 1'b1;
        s = cyc + 1;
        tick(1);
        tx_start_b = 1'b0;
        tick(8690);
        chk("baud_pre_idle",   32'(line_b[s - 1]), 32'd1);
        chk("baud_start_low",  32'(cnt(4, s, s + 867)), 32'd0);
        chk("baud_low_run",    32'(cnt(4, s, s + 7811)), 32'd0);
        chk("baud_stop_high",  32'(cnt(4, s + 7812, s + 8679)), 32'd868);
        chk("baud_done_at",    32'(done_b[s + 8679]), 32'd1);
        chk("baud_done_once",  32'(cnt(5, s, s + 8685)), 32'd1);
        chk("baud_busy_len",   32'(cnt(6, s, s + 8685)), 32'd8680);
        chk("baud_line_after", 32'(line_b[s + 8680]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
